// File: rtl/hms_clock_core.sv
// Time-of-day counter in BCD (HH:MM:SS) advanced by a synchronised 1 Hz input,
// with a three-state set FSM for adjusting hours and minutes.
module hms_clock_core #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_50mhz,
  input  logic       reset,
  input  logic       clock_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [1:0] hr_tens,
  output logic [3:0] hr_ones,
  output logic [2:0] min_tens,
  output logic [3:0] min_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       sec_tick,
  output logic [1:0] mode
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   history_q;
  logic                   rise;

  logic [1:0] hr_tens_d, hr_inc_tens;
  logic [3:0] hr_ones_d, hr_inc_ones;
  logic [2:0] min_tens_d, min_inc_tens;
  logic [3:0] min_ones_d, min_inc_ones;
  logic [2:0] sec_tens_d, sec_inc_tens;
  logic [3:0] sec_ones_d, sec_inc_ones;
  logic       sec_carry, min_carry;
  logic       sec_tick_d;

  assign rise = sync_q[SYNC_STAGES-1] & ~history_q;
  assign mode = state_q;

  // Per-field BCD successors; the FSM below decides which of them are taken.
  always_comb begin
    sec_inc_ones = sec_ones + 4'd1;
    sec_inc_tens = sec_tens;
    if (sec_ones == 4'd9) begin
      sec_inc_ones = '0;
      sec_inc_tens = (sec_tens == 3'd5) ? '0 : sec_tens + 3'd1;
    end
    min_inc_ones = min_ones + 4'd1;
    min_inc_tens = min_tens;
    if (min_ones == 4'd9) begin
      min_inc_ones = '0;
      min_inc_tens = (min_tens == 3'd5) ? '0 : min_tens + 3'd1;
    end
    hr_inc_ones = hr_ones + 4'd1;
    hr_inc_tens = hr_tens;
    if (hr_tens == 2'd2 && hr_ones == 4'd3) begin
      hr_inc_ones = '0;
      hr_inc_tens = '0;
    end else if (hr_ones == 4'd9) begin
      hr_inc_ones = '0;
      hr_inc_tens = hr_tens + 2'd1;
    end
    sec_carry = (sec_tens == 3'd5) && (sec_ones == 4'd9);
    min_carry = (min_tens == 3'd5) && (min_ones == 4'd9);
  end

  always_comb begin
    state_d    = state_q;
    hr_tens_d  = hr_tens;
    hr_ones_d  = hr_ones;
    min_tens_d = min_tens;
    min_ones_d = min_ones;
    sec_tens_d = sec_tens;
    sec_ones_d = sec_ones;
    sec_tick_d = 1'b0;
    // btn_mode outranks btn_inc, which outranks a 1 Hz rise.
    unique case (state_q)
      RUN: begin
        if (btn_mode) begin
          state_d    = SET_HR;
          sec_tens_d = '0;
          sec_ones_d = '0;
        end else if (rise) begin
          sec_tick_d = 1'b1;
          sec_tens_d = sec_inc_tens;
          sec_ones_d = sec_inc_ones;
          if (sec_carry) begin
            min_tens_d = min_inc_tens;
            min_ones_d = min_inc_ones;
            if (min_carry) begin
              hr_tens_d = hr_inc_tens;
              hr_ones_d = hr_inc_ones;
            end
          end
        end
      end
      SET_HR: begin
        if (btn_mode) begin
          state_d = SET_MIN;
        end else if (btn_inc) begin
          hr_tens_d = hr_inc_tens;
          hr_ones_d = hr_inc_ones;
        end
      end
      SET_MIN: begin
        if (btn_mode) begin
          state_d = RUN;
        end else if (btn_inc) begin
          min_tens_d = min_inc_tens;
          min_ones_d = min_inc_ones;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_50mhz or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      sync_q    <= '0;
      history_q <= 1'b0;
      hr_tens   <= '0;
      hr_ones   <= '0;
      min_tens  <= '0;
      min_ones  <= '0;
      sec_tens  <= '0;
      sec_ones  <= '0;
      sec_tick  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], clock_1hz};
      history_q <= sync_q[SYNC_STAGES-1];
      hr_tens   <= hr_tens_d;
      hr_ones   <= hr_ones_d;
      min_tens  <= min_tens_d;
      min_ones  <= min_ones_d;
      sec_tens  <= sec_tens_d;
      sec_ones  <= sec_ones_d;
      sec_tick  <= sec_tick_d;
    end
  end

endmodule
